// File: rtl/threshold_hysteresis_detector.sv
// Hysteresis level detector for the smoothed sample stream: qualified rise/fall, pulses,
// saturating rise counter. Define THD_PEAK_TRACK_EN to build the per-high-period peak register.
module threshold_hysteresis_detector #(
  parameter int DATA_WIDTH  = 8,
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  areset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] thr_high,
  input  logic [DATA_WIDTH-1:0] thr_low,
  input  logic                  clear_cnt,
  output logic                  level,
  output logic                  rise_pulse,
  output logic                  fall_pulse,
  output logic [CNT_WIDTH-1:0]  event_count,
  output logic                  cfg_err,
  output logic [DATA_WIDTH-1:0] peak_value
);

  typedef enum logic [1:0] {S_LOW, S_RISE_PEND, S_HIGH, S_FALL_PEND} state_t;

  localparam logic [7:0] QCNT_LAST = 8'(HOLD_CYCLES - 1);

  state_t      state_q, state_d;
  logic [7:0]  qcnt_q, qcnt_d;
  logic        rise_acc, fall_acc;
  logic        active;
  logic        hi_qual, lo_qual;

  // A registered threshold fault freezes evaluation exactly like enable=0.
  assign active  = enable & ~cfg_err;
  assign hi_qual = (data_in >= thr_high);
  assign lo_qual = (data_in <= thr_low);

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    qcnt_d   = qcnt_q;
    rise_acc = 1'b0;
    fall_acc = 1'b0;
    if (active) begin
      case (state_q)
        S_LOW: if (hi_qual) begin
          state_d = S_RISE_PEND;
          qcnt_d  = 8'd1;
        end
        S_RISE_PEND: begin
          if (!hi_qual) begin
            state_d = S_LOW;
            qcnt_d  = 8'd0;
          end else if (qcnt_q == QCNT_LAST) begin
            state_d  = S_HIGH;
            qcnt_d   = 8'd0;
            rise_acc = 1'b1;
          end else begin
            qcnt_d = qcnt_q + 8'd1;
          end
        end
        S_HIGH: if (lo_qual) begin
          state_d = S_FALL_PEND;
          qcnt_d  = 8'd1;
        end
        S_FALL_PEND: begin
          if (!lo_qual) begin
            state_d = S_HIGH;
            qcnt_d  = 8'd0;
          end else if (qcnt_q == QCNT_LAST) begin
            state_d  = S_LOW;
            qcnt_d   = 8'd0;
            fall_acc = 1'b1;
          end else begin
            qcnt_d = qcnt_q + 8'd1;
          end
        end
        default: begin
          state_d = S_LOW;
          qcnt_d  = 8'd0;
        end
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q    <= S_LOW;
      qcnt_q     <= 8'd0;
      level      <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      state_q    <= state_d;
      qcnt_q     <= qcnt_d;
      rise_pulse <= rise_acc;
      fall_pulse <= fall_acc;
      cfg_err    <= (thr_low > thr_high);
      if (rise_acc)      level <= 1'b1;
      else if (fall_acc) level <= 1'b0;
    end
  end

  // A clear coinciding with a rise still records that rise.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      event_count <= '0;
    end else if (clear_cnt) begin
      event_count <= {{(CNT_WIDTH-1){1'b0}}, rise_acc};
    end else if (rise_acc && (event_count != {CNT_WIDTH{1'b1}})) begin
      event_count <= event_count + 1'b1;
    end
  end

`ifdef THD_PEAK_TRACK_EN
  logic [DATA_WIDTH-1:0] peak_q;

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      peak_q     <= '0;
      peak_value <= '0;
    end else begin
      if (rise_acc) begin
        peak_q <= data_in;
      end else if (active && (state_q == S_HIGH || state_q == S_FALL_PEND) &&
                   (data_in > peak_q)) begin
        peak_q <= data_in;
      end
      if (fall_acc) peak_value <= (data_in > peak_q) ? data_in : peak_q;
    end
  end
`else
  assign peak_value = '0;
`endif

endmodule

// File: tb/tb_threshold_hysteresis_detector.sv
// Directed scoreboard bench for threshold_hysteresis_detector (HOLD_CYCLES=4, CNT_WIDTH=2).
module tb_threshold_hysteresis_detector;

  localparam int DW = 8;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          areset;
  logic [DW-1:0] data_in;
  logic          enable;
  logic [DW-1:0] thr_high;
  logic [DW-1:0] thr_low;
  logic          clear_cnt;
  logic          level, rise_pulse, fall_pulse, cfg_err;
  logic [CW-1:0] event_count;
  logic [DW-1:0] peak_value;

  threshold_hysteresis_detector #(.DATA_WIDTH(DW), .HOLD_CYCLES(4), .CNT_WIDTH(CW)) dut (
    .clk(clk), .areset(areset), .data_in(data_in), .enable(enable),
    .thr_high(thr_high), .thr_low(thr_low), .clear_cnt(clear_cnt),
    .level(level), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
    .event_count(event_count), .cfg_err(cfg_err), .peak_value(peak_value)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          level;
    logic          rise;
    logic          fall;
    logic [CW-1:0] cnt;
    logic          cfg;
    logic [DW-1:0] peak;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   step_no  = 0;

  logic          rst_v = 1'b1;
  logic [DW-1:0] th_v  = 8'd100;
  logic [DW-1:0] tl_v  = 8'd60;
  logic [DW-1:0] exp_peak = 8'd0;

  function automatic logic [DW-1:0] pk(input logic [DW-1:0] v);
`ifdef THD_PEAK_TRACK_EN
    return v;
`else
    return '0;
`endif
  endfunction

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_errors++;
      $display("FAIL step %0d %s: got %0d expected %0d", step_no, name, actual, expected);
    end
  endtask

  // Drive one cycle of stimulus and queue the outputs expected after the following edge.
  task automatic step(input logic [DW-1:0] d, input bit en, input bit clr,
                      input bit lv, input bit rs, input bit fl, input int cnt, input bit cf);
    exp_t e;
    @(negedge clk);
    areset    = rst_v;
    data_in   = d;
    enable    = en;
    clear_cnt = clr;
    thr_high  = th_v;
    thr_low   = tl_v;
    e.level = lv;
    e.rise  = rs;
    e.fall  = fl;
    e.cnt   = CW'(cnt);
    e.cfg   = cf;
    e.peak  = pk(exp_peak);
    exp_q.push_back(e);
  endtask

  task automatic run(input logic [DW-1:0] d, input int n, input bit lv, input int cnt,
                     input bit cf);
    for (int i = 0; i < n; i++) step(d, 1'b1, 1'b0, lv, 1'b0, 1'b0, cnt, cf);
  endtask

  // Monitor: every output is registered, so each edge presents one response.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        step_no++;
        check("level",       int'(level),       int'(e.level));
        check("rise_pulse",  int'(rise_pulse),  int'(e.rise));
        check("fall_pulse",  int'(fall_pulse),  int'(e.fall));
        check("event_count", int'(event_count), int'(e.cnt));
        check("cfg_err",     int'(cfg_err),     int'(e.cfg));
        check("peak_value",  int'(peak_value),  int'(e.peak));
      end
    end
  end

  initial begin
    areset = 1'b1; data_in = '0; enable = 1'b0; clear_cnt = 1'b0;
    thr_high = 8'd100; thr_low = 8'd60;

    // Reset values while the input already qualifies.
    step(8'd120, 1, 0, 0, 0, 0, 0, 0);
    step(8'd120, 1, 0, 0, 0, 0, 0, 0);
    rst_v = 1'b0;

    // Rise after the 4th enabled edge, pulse one cycle wide.
    run(8'd120, 3, 0, 0, 0);
    step(8'd120, 1, 0, 1, 1, 0, 1, 0);
    step(8'd140, 1, 0, 1, 0, 0, 1, 0);
    step(8'd130, 1, 0, 1, 0, 0, 1, 0);
    // Hysteresis band keeps HIGH; then a fall reports peak 140.
    run(8'd80, 10, 1, 1, 0);
    run(8'd50, 3, 1, 1, 0);
    exp_peak = 8'd140;
    step(8'd50, 1, 0, 0, 0, 1, 1, 0);
    run(8'd50, 1, 0, 1, 0);

    // A non-qualifying sample restarts qualification.
    run(8'd120, 3, 0, 1, 0);
    run(8'd90, 1, 0, 1, 0);
    run(8'd120, 3, 0, 1, 0);
    step(8'd120, 1, 0, 1, 1, 0, 2, 0);
    run(8'd50, 3, 1, 2, 0);
    exp_peak = 8'd120;
    step(8'd50, 1, 0, 0, 0, 1, 2, 0);

    // Disabled cycles neither count nor break qualification, even with a low sample.
    for (int i = 0; i < 3; i++) begin
      step(8'd120, 1, 0, 0, 0, 0, 2, 0);
      step(8'd90,  0, 0, 0, 0, 0, 2, 0);
    end
    step(8'd120, 1, 0, 1, 1, 0, 3, 0);
    step(8'd120, 0, 0, 1, 0, 0, 3, 0);
    run(8'd50, 3, 1, 3, 0);
    step(8'd50, 1, 0, 0, 0, 1, 3, 0);

    // Inverted thresholds freeze the FSM; the restoring edge is still frozen.
    tl_v = 8'd110;
    step(8'd60, 1, 0, 0, 0, 0, 3, 1);
    run(8'd120, 5, 0, 3, 1);
    tl_v = 8'd60;
    step(8'd120, 1, 0, 0, 0, 0, 3, 0);
    run(8'd120, 3, 0, 3, 0);
    // Fourth rise: counter stays saturated at 3.
    step(8'd120, 1, 0, 1, 1, 0, 3, 0);

    // clear_cnt alone, then clear coinciding with a rise at the exact threshold.
    step(8'd120, 1, 1, 1, 0, 0, 0, 0);
    run(8'd50, 3, 1, 0, 0);
    step(8'd50, 1, 0, 0, 0, 1, 0, 0);
    run(8'd100, 3, 0, 0, 0);
    step(8'd100, 1, 1, 1, 1, 0, 1, 0);
    // Fall at exactly thr_low; peak is the seed sample 100.
    run(8'd60, 3, 1, 1, 0);
    exp_peak = 8'd100;
    step(8'd60, 1, 0, 0, 0, 1, 1, 0);

    // Reset mid-qualification discards the pending rise.
    run(8'd120, 2, 0, 1, 0);
    rst_v = 1'b1;
    exp_peak = 8'd0;
    step(8'd120, 1, 0, 0, 0, 0, 0, 0);
    rst_v = 1'b0;
    run(8'd120, 3, 0, 0, 0);
    step(8'd120, 1, 0, 1, 1, 0, 1, 0);
    step(8'd120, 1, 0, 1, 0, 0, 1, 0);

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d entries left expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
